// File: rtl/br_stack_pkg.sv
// Branch checkpoint stack shared definitions: branch-state encoding
// (also used by the free list) and checkpoint field widths.
`ifndef BR_DEFINES_SVH
`define BR_DEFINES_SVH
`define BR_STATE_W    2
`define BR_NONE       2'b00
`define BR_PR_CORRECT 2'b01
`define BR_PR_WRONG   2'b10
`endif

package br_stack_pkg;

  // Width of a free-list head pointer saved in each checkpoint.
  localparam int FL_HEAD_W = 5;

  // Resolution status broadcast to the free list.
  typedef enum logic [`BR_STATE_W-1:0] {
    BR_NONE       = `BR_NONE,
    BR_PR_CORRECT = `BR_PR_CORRECT,
    BR_PR_WRONG   = `BR_PR_WRONG
  } br_state_e;

  // Maps a resolution strobe and its outcome to the broadcast state.
  function automatic br_state_e br_state_of(input logic en, input logic mispredict);
    if (!en) begin
      return BR_NONE;
    end
    return mispredict ? BR_PR_WRONG : BR_PR_CORRECT;
  endfunction

endpackage

// File: rtl/br_alloc_pe.sv
// Lowest-zero priority encoder: picks the lowest-index free checkpoint
// slot as a one-hot grant and flags when every slot is busy.
module br_alloc_pe #(
  parameter int N = 4
) (
  input  logic [N-1:0] busy_i,
  output logic [N-1:0] grant_o,
  output logic         none_free_o
);

  logic found;

  // Scan from slot 0 upward and grant the first slot that is not busy.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!busy_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign none_free_o = &busy_i;

endmodule

// File: rtl/br_stack.sv
// Branch checkpoint stack: saves the free-list head and ROB tail per
// dispatched branch in a one-hot tagged slot, releases the slot on a
// correct prediction and drives recovery state on a misprediction.
module br_stack
  import br_stack_pkg::*;
#(
  parameter int BR_DEPTH  = 4,
  parameter int ROB_IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_br_en_i,
  input  logic [FL_HEAD_W-1:0]   fl_cur_head_i,
  input  logic [ROB_IDX_W-1:0]   rob_tail_i,
  input  logic                   br_result_en_i,
  input  logic [BR_DEPTH-1:0]    br_result_tag_i,
  input  logic                   br_mispredict_i,
  output logic [BR_DEPTH-1:0]    br_tag_o,
  output logic [BR_DEPTH-1:0]    br_mask_o,
  output logic                   full_o,
  output logic [`BR_STATE_W-1:0] br_state_o,
  output logic [FL_HEAD_W-1:0]   rc_head_o,
  output logic [ROB_IDX_W-1:0]   rc_rob_tail_o,
  output logic [BR_DEPTH-1:0]    squash_mask_o
);

  logic [BR_DEPTH-1:0]  valid_q, valid_d;
  logic [FL_HEAD_W-1:0] fl_head_q  [BR_DEPTH];
  logic [FL_HEAD_W-1:0] fl_head_d  [BR_DEPTH];
  logic [ROB_IDX_W-1:0] rob_tail_q [BR_DEPTH];
  logic [ROB_IDX_W-1:0] rob_tail_d [BR_DEPTH];
  logic [BR_DEPTH-1:0]  dep_mask_q [BR_DEPTH];
  logic [BR_DEPTH-1:0]  dep_mask_d [BR_DEPTH];

  logic [BR_DEPTH-1:0]  free_slot;
  logic                 none_free;
  logic                 resolve_en;
  logic                 correct_en;
  logic                 wrong_en;
  logic                 tag_hit;
  logic                 push_fire;
  logic [BR_DEPTH-1:0]  squash_mask;
  logic [BR_DEPTH-1:0]  new_dep_mask;
  logic [FL_HEAD_W-1:0] rc_head;
  logic [ROB_IDX_W-1:0] rc_rob_tail;
  br_state_e            br_state;

  br_alloc_pe #(
    .N(BR_DEPTH)
  ) u_alloc_pe (
    .busy_i      (valid_q),
    .grant_o     (free_slot),
    .none_free_o (none_free)
  );

  // Reset masks the resolution strobe so recovery outputs go quiet at once.
  assign resolve_en = br_result_en_i & ~rst;
  assign correct_en = resolve_en & ~br_mispredict_i;
  assign wrong_en   = resolve_en & br_mispredict_i;
  assign tag_hit    = |(br_result_tag_i & valid_q);

  // A branch dispatching alongside a mispredict is younger and dies with it.
  assign push_fire  = dispatch_br_en_i & ~none_free & ~wrong_en & ~rst;

  // The new slot depends on every outstanding branch except one retiring now.
  assign new_dep_mask = valid_q & ~(correct_en ? br_result_tag_i : {BR_DEPTH{1'b0}});

  assign br_state = br_state_of(resolve_en, br_mispredict_i);

  // Recovery lookup: read the tagged slot and gather its younger dependents.
  always_comb begin
    squash_mask = '0;
    rc_head     = '0;
    rc_rob_tail = '0;
    if (wrong_en && tag_hit) begin
      squash_mask = br_result_tag_i & valid_q;
      for (int i = 0; i < BR_DEPTH; i++) begin
        if (br_result_tag_i[i] && valid_q[i]) begin
          rc_head     = rc_head | fl_head_q[i];
          rc_rob_tail = rc_rob_tail | rob_tail_q[i];
        end
        if (valid_q[i] && (|(dep_mask_q[i] & br_result_tag_i))) begin
          squash_mask[i] = 1'b1;
        end
      end
    end
  end

  // Slot next-state: retire, squash, then allocate the pushed branch.
  always_comb begin
    valid_d    = valid_q;
    fl_head_d  = fl_head_q;
    rob_tail_d = rob_tail_q;
    dep_mask_d = dep_mask_q;
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (correct_en) begin
        dep_mask_d[i] = dep_mask_q[i] & ~br_result_tag_i;
        if (br_result_tag_i[i]) begin
          valid_d[i]    = 1'b0;
          dep_mask_d[i] = '0;
        end
      end
      if (squash_mask[i]) begin
        valid_d[i]    = 1'b0;
        dep_mask_d[i] = '0;
      end
      if (push_fire && free_slot[i]) begin
        valid_d[i]    = 1'b1;
        fl_head_d[i]  = fl_cur_head_i;
        rob_tail_d[i] = rob_tail_i;
        dep_mask_d[i] = new_dep_mask;
      end
    end
  end

  // Checkpoint slot registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BR_DEPTH; i++) begin
        fl_head_q[i]  <= '0;
        rob_tail_q[i] <= '0;
        dep_mask_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < BR_DEPTH; i++) begin
        fl_head_q[i]  <= fl_head_d[i];
        rob_tail_q[i] <= rob_tail_d[i];
        dep_mask_q[i] <= dep_mask_d[i];
      end
    end
  end

  assign br_tag_o      = push_fire ? free_slot : '0;
  assign br_mask_o     = valid_q;
  assign full_o        = none_free;
  assign br_state_o    = br_state;
  assign rc_head_o     = rc_head;
  assign rc_rob_tail_o = rc_rob_tail;
  assign squash_mask_o = squash_mask;

endmodule

// File: doc/br_stack.md
# br_stack

Branch checkpoint stack for the R10K-style out-of-order core. On each dispatched branch it saves the free-list head and ROB tail in a one-hot-tagged checkpoint slot. On resolution it either releases the slot (correct prediction) or drives the recovery head, ROB tail, branch state and squash mask back to the free list, ROB and RS (misprediction). It sits between the decoder/dispatch stage, the branch execution unit and the free list's `branch_state_i`/`rc_head_i` recovery inputs.

## Interface
- `BR_DEPTH`, 4: number of checkpoint slots; tags and masks are `BR_DEPTH` bits, one-hot.
- `ROB_IDX_W`, 5: ROB tail pointer width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `dispatch_br_en_i` input 1: a branch dispatches this cycle; push a checkpoint.
- `fl_cur_head_i` input 5: free-list head captured on push.
- `rob_tail_i` input `ROB_IDX_W`: ROB tail captured on push.
- `br_result_en_i` input 1: branch unit resolves a branch this cycle.
- `br_result_tag_i` input `BR_DEPTH`: one-hot tag of the resolving branch.
- `br_mispredict_i` input 1: 1 = mispredicted, 0 = correct.
- `br_tag_o` output `BR_DEPTH`: one-hot tag assigned to the dispatching branch; 0 when full or not pushing.
- `br_mask_o` output `BR_DEPTH`: valid vector of outstanding branches; dispatched instructions carry it.
- `full_o` output 1: no free slot; dispatch of a branch must stall.
- `br_state_o` output `` `BR_STATE_W ``: `BR_NONE`, `BR_PR_CORRECT` or `BR_PR_WRONG`; connects to the free list `branch_state_i`.
- `rc_head_o` output 5: saved free-list head of the mispredicted branch; connects to the free list `rc_head_i`.
- `rc_rob_tail_o` output `ROB_IDX_W`: saved ROB tail of the mispredicted branch.
- `squash_mask_o` output `BR_DEPTH`: tags to kill (the mispredicted branch plus every younger dependent branch).

## Operation
- Per slot state:
  - `valid`
  - `fl_head[4:0]`
  - `rob_tail`
  - `dep_mask[BR_DEPTH]`: the `br_mask_o` value at allocation, i.e. the older branches.
- Push:
  - Fires when `dispatch_br_en_i && !full_o`.
  - Allocates the lowest-index invalid slot and sets its `valid`.
  - Stores `fl_cur_head_i`, `rob_tail_i` and the current `br_mask_o`.
  - `br_tag_o` is the one-hot of that slot.
  - A push while `full_o` is ignored; the stall is the decoder's responsibility.
- Correct resolution (`br_result_en_i && !br_mispredict_i`):
  - `br_state_o = BR_PR_CORRECT`.
  - The tagged slot's `valid` clears.
  - The tag bit clears from every slot's `dep_mask`.
- Mispredict (`br_result_en_i && br_mispredict_i`):
  - `br_state_o = BR_PR_WRONG`.
  - `rc_head_o` and `rc_rob_tail_o` come from the tagged slot.
  - `squash_mask_o` = tag OR (OR of tags of valid slots whose `dep_mask` contains the tag).
  - Every slot in `squash_mask_o` is invalidated at the next edge.
- With no resolution:
  - `br_state_o = BR_NONE`.
  - `rc_head_o`, `rc_rob_tail_o` and `squash_mask_o` are 0.
- Resolving an invalid tag is a protocol error. Outputs are then state per `br_mispredict_i`, with zero head/tail/mask; the bench asserts this never happens.

## Timing
- `br_tag_o`, `full_o`, `br_mask_o`:
  - Combinational from registered slot state.
  - `full_o` does not see same-cycle frees; a slot freed at edge N is allocatable in cycle N+1.
- Resolution outputs (`br_state_o`, `rc_*`, `squash_mask_o`):
  - Combinational, in the same cycle as `br_result_en_i`.
  - This matches the free list sampling `branch_state_i`/`rc_head_i` at the same edge.
  - Slot state updates at that edge.
- Push and correct resolve in the same cycle:
  - Both take effect.
  - The new slot's `dep_mask` excludes the resolved tag.
- Push and mispredict in the same cycle:
  - The push is suppressed; the dispatching branch is younger and squashed.
  - `br_tag_o` is forced to 0.
- Reset: all slots invalid, all masks 0, all outputs 0, `br_state_o = BR_NONE`.
- Reset asserted mid-operation clears state immediately (async); pending resolutions are discarded.

## Structure
- Shared defines header (with the free list) holds:
  - `` `BR_STATE_W `` = 2.
  - `BR_NONE` = 2'b00, `BR_PR_CORRECT` = 2'b01, `BR_PR_WRONG` = 2'b10.
- Sub-module `br_alloc_pe`: parameterized lowest-zero priority encoder producing the one-hot free slot and a `none_free` flag (drives `full_o`).
- Slot array, dep-mask clear and squash logic live in `br_stack`.

## Test plan
- Reset, then push with `fl_cur_head_i`=7, `rob_tail_i`=3 → `br_tag_o`=4'b0001, `br_mask_o`=4'b0001 next cycle, `full_o`=0.
- Push 4 branches (heads 1, 2, 3, 4) → tags 0001, 0010, 0100, 1000; `full_o`=1. A fifth push leaves the mask 4'b1111 and `br_tag_o`=0.
- With 4 outstanding, mispredict tag 0010 → same cycle: `br_state_o`=`BR_PR_WRONG`, `rc_head_o`=2, `squash_mask_o`=4'b1110. Next cycle `br_mask_o`=4'b0001.
- Correct resolve tag 0001 while pushing (head 9) with slot 0001 held → the next push after the edge gets tag 0001 (slot reused). The pushing branch's `dep_mask` excludes 0001; a later mispredict of an older-free tag does not squash it.
- Push and mispredict in the same cycle → no slot allocated, `br_tag_o`=0, `squash_mask_o` excludes the would-be slot.
- Assert `rst` asynchronously between edges with 3 outstanding → `br_mask_o`=0, `full_o`=0, `br_state_o`=`BR_NONE` immediately.
